// File: rtl/i2c_csr_bridge_pkg.sv
// Shared CSR bus constants: default address width, target address and block base addresses.
package i2c_csr_bridge_pkg;

  localparam int                         CSR_AW_DEFAULT   = 5;
  localparam logic [6:0]                 I2C_ADDR_DEFAULT = 7'h4a;

  // CSR address map: one 8-register window per function block
  localparam logic [CSR_AW_DEFAULT-1:0]  WDT_BASE  = 5'h00;
  localparam logic [CSR_AW_DEFAULT-1:0]  GPIO_BASE = 5'h08;
  localparam logic [CSR_AW_DEFAULT-1:0]  CNT_BASE  = 5'h10;
  localparam logic [CSR_AW_DEFAULT-1:0]  LED_BASE  = 5'h18;

endpackage

// File: rtl/i2c_bus_cond.sv
// I2C bus conditioner: 2-FF synchronisers on SCL/SDA and single-clk START, STOP
// and SCL edge pulses derived from the synchronised levels.
module i2c_bus_cond (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_q;
  logic       sda_q;
  logic       scl_s;

  // NOTE: reset to 1 (idle bus level) so leaving reset never fakes a START or an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_csr_bridge.sv
// I2C target mastering the CSR bus: pointer byte then write bytes, or reads from the pointer.
// Define I2C_CSR_AUTOINC_EN to advance the pointer after every written or loaded read byte.
module i2c_csr_bridge
  import i2c_csr_bridge_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = I2C_ADDR_DEFAULT,
  parameter int         CSR_AW   = CSR_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [CSR_AW-1:0] csr_a,
  output logic [7:0]        csr_di,
  output logic              csr_we,
  input  logic [7:0]        csr_do
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t            state, state_d;
  logic              scl_rise, scl_fall, start, stop, sda_s;
  logic              rise, fall, byte_done, ack_end, is_ack_state, is_byte_state;
  logic [6:0]        shift;
  logic [7:0]        rx_byte;
  logic [2:0]        cnt;
  logic              ack_seen, rw;
  logic [CSR_AW-1:0] ptr;
  logic              sda_oe_d, we_d, load_rd, ptr_load;

  i2c_bus_cond u_bus_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  // Bus conditions outrank bit events arriving in the same clk.
  assign rise          = scl_rise & ~start & ~stop;
  assign fall          = scl_fall & ~start & ~stop;
  assign byte_done     = rise && (cnt == 3'd7);
  assign ack_end       = fall && ack_seen;
  assign rx_byte       = {shift, sda_s};
  assign is_ack_state  = state inside {ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA_ACK};
  assign is_byte_state = state inside {ADDR, PTR, WDATA, RDATA};
  assign csr_a         = ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (start) begin
      state_d = ADDR;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      case (state)
        ADDR:      if (byte_done) state_d = (rx_byte[7:1] == I2C_ADDR) ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (ack_end)   state_d = rw ? RDATA : PTR;
        PTR:       if (byte_done) state_d = PTR_ACK;
        PTR_ACK:   if (ack_end)   state_d = WDATA;
        WDATA:     if (byte_done) state_d = WDATA_ACK;
        WDATA_ACK: if (ack_end)   state_d = WDATA;
        RDATA:     if (byte_done) state_d = RDATA_ACK;
        RDATA_ACK: begin
          if (rise && sda_s) state_d = IDLE;
          else if (ack_end)  state_d = RDATA;
        end
        default:   state_d = IDLE;
      endcase
    end
  end

  // ACK states: the first SCL fall drives ACK (or releases for a read), the fall after the ACK clock ends it.
  always_comb begin
    // NOTE: every output gets a default first so this block cannot infer a latch.
    sda_oe_d = sda_oe;
    we_d     = 1'b0;
    load_rd  = 1'b0;
    ptr_load = 1'b0;
    if (start || stop) begin
      sda_oe_d = 1'b0;
    end else begin
      case (state)
        ADDR_ACK: begin
          if (fall) begin
            if (!ack_seen) begin
              sda_oe_d = 1'b1;
            end else if (rw) begin
              load_rd  = 1'b1;
              sda_oe_d = ~csr_do[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: if (fall) sda_oe_d = ~ack_seen;
        PTR:                ptr_load = byte_done;
        WDATA:              we_d = byte_done;
        RDATA:              if (fall) sda_oe_d = ~shift[6];
        RDATA_ACK: begin
          if (fall) begin
            if (!ack_seen) begin
              sda_oe_d = 1'b0;
            end else begin
              load_rd  = 1'b1;
              sda_oe_d = ~csr_do[7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sda_oe   <= 1'b0;
      csr_we   <= 1'b0;
      csr_di   <= 8'h00;
      ptr      <= '0;
      shift    <= '0;
      cnt      <= 3'd0;
      ack_seen <= 1'b0;
      rw       <= 1'b0;
    end else begin
      sda_oe   <= sda_oe_d;
      csr_we   <= we_d;
      ack_seen <= is_ack_state & (ack_seen | rise);
      if (we_d) csr_di <= rx_byte;
      if (state == ADDR && byte_done) rw <= rx_byte[0];

      if (start || stop)              cnt <= 3'd0;
      else if (rise && is_byte_state) cnt <= cnt + 3'd1;

      if (rise && (state inside {ADDR, PTR, WDATA})) shift <= rx_byte[6:0];
      else if (load_rd)                              shift <= csr_do[6:0];
      else if (fall && state == RDATA)               shift <= {shift[5:0], 1'b0};

      if (ptr_load) ptr <= rx_byte[CSR_AW-1:0];
`ifdef I2C_CSR_AUTOINC_EN
      // The strobe cycle still presents the old pointer; the advance lands one clk later.
      else if (csr_we || load_rd) ptr <= ptr + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_csr_bridge.sv
// Self-checking bench for i2c_csr_bridge: bit-level I2C controller, CSR slave returning 0xa0+a,
// and a pointer/transaction reference model. Honours I2C_CSR_AUTOINC_EN.
module tb_i2c_csr_bridge;
  import i2c_csr_bridge_pkg::*;

  localparam int AW = 5;
`ifdef I2C_CSR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scl = 1'b1;
  logic          tb_sda = 1'b1;
  logic          sda_bus;
  logic          sda_oe, csr_we;
  logic [AW-1:0] csr_a;
  logic [7:0]    csr_di, csr_do;

  wr_t         got_wr[$];
  wr_t         exp_wr[$];
  bit          oe_seen;
  int          checks = 0;
  int          failures = 0;
  int unsigned mptr = 0;

  always #5 clk = ~clk;

  assign sda_bus = tb_sda & ~sda_oe;
  assign csr_do  = 8'ha0 + {3'b000, csr_a};

  i2c_csr_bridge #(.I2C_ADDR(7'h4a), .CSR_AW(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl_i  (scl),
    .sda_i  (sda_bus),
    .sda_oe (sda_oe),
    .csr_a  (csr_a),
    .csr_di (csr_di),
    .csr_we (csr_we),
    .csr_do (csr_do)
  );

  always @(negedge clk) begin
    if (csr_we) got_wr.push_back({csr_a, csr_di});
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  // ---------------- bus driver ----------------
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_sda = 1'b1; wclk(4);
    scl = 1'b1;    wclk(4);
    tb_sda = 1'b0; wclk(4);
    scl = 1'b0;    wclk(4);
  endtask

  task automatic i2c_stop();
    tb_sda = 1'b0; wclk(4);
    scl = 1'b1;    wclk(4);
    tb_sda = 1'b1; wclk(8);
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    tb_sda = b;    wclk(4);
    scl = 1'b1;    wclk(4);
    r = sda_bus;   wclk(4);
    scl = 1'b0;    wclk(4);
  endtask

  task automatic i2c_wbyte(input logic [7:0] b, output bit ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
    i2c_bit(1'b1, r);
    ack = (r === 1'b0);
  endtask

  task automatic i2c_rbyte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(nack, r);
  endtask

  // ---------------- reference model ----------------
  task automatic model_set_ptr(input logic [7:0] p);
    mptr = p % 32;
  endtask

  task automatic model_write(input logic [7:0] d);
    logic [AW-1:0] a;
    a = mptr[AW-1:0];
    exp_wr.push_back({a, d});
    if (AUTOINC) mptr = (mptr + 1) % 32;
  endtask

  task automatic model_read(output logic [7:0] d);
    d = 8'ha0 + 8'(mptr);
    if (AUTOINC) mptr = (mptr + 1) % 32;
  endtask

  task automatic clear_logs();
    got_wr.delete();
    exp_wr.delete();
    oe_seen = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    wclk(3);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (csr_we !== 1'b0) begin failures++; $display("FAIL reset_csr_we got=%b exp=0", csr_we); end
    checks++; if (csr_a !== '0)    begin failures++; $display("FAIL reset_csr_a got=%h exp=0", csr_a); end
    checks++; if (csr_di !== 8'h0) begin failures++; $display("FAIL reset_csr_di got=%h exp=0", csr_di); end
    rst_n = 1'b1;
    mptr = 0;
    wclk(4);
  endtask

  task automatic test_basic_write();
    bit a0, a1, a2;
    clear_logs();
    i2c_start();
    i2c_wbyte(8'h94, a0); i2c_wbyte(8'h02, a1); i2c_wbyte(8'h6b, a2);
    i2c_stop();
    model_set_ptr(8'h02); model_write(8'h6b);
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL basic_acks got=%b exp=111", {a0, a1, a2}); end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL basic_wr_count got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL basic_wr%0d got a=%h d=%h exp a=%h d=%h", i, got_wr[i].a, got_wr[i].d, exp_wr[i].a, exp_wr[i].d); end
    end
  endtask

  task automatic test_wrong_addr();
    bit a0, a1, a2;
    clear_logs();
    i2c_start();
    i2c_wbyte(8'h90, a0); i2c_wbyte(8'h02, a1); i2c_wbyte(8'h6b, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL nomatch_acks got=%b exp=000", {a0, a1, a2}); end
    checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL nomatch_sda_oe got=%b exp=0", oe_seen); end
    checks++; if (got_wr.size() != 0) begin failures++; $display("FAIL nomatch_wr_count got=%0d exp=0", got_wr.size()); end
  endtask

  task automatic test_wrap();
    bit a0, a1, a2, a3;
    clear_logs();
    i2c_start();
    i2c_wbyte(8'h94, a0); i2c_wbyte(8'h1f, a1); i2c_wbyte(8'hc1, a2); i2c_wbyte(8'h10, a3);
    i2c_stop();
    model_set_ptr(8'h1f); model_write(8'hc1); model_write(8'h10);
    checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin failures++; $display("FAIL wrap_acks got=%b exp=1111", {a0, a1, a2, a3}); end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL wrap_wr_count got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL wrap_wr%0d got a=%h d=%h exp a=%h d=%h", i, got_wr[i].a, got_wr[i].d, exp_wr[i].a, exp_wr[i].d); end
    end
  endtask

  task automatic test_read();
    bit a0, a1, a2;
    logic [7:0] d0, d1, e0, e1;
    clear_logs();
    i2c_start();
    i2c_wbyte(8'h94, a0); i2c_wbyte(8'h01, a1);
    i2c_start();
    i2c_wbyte(8'h95, a2);
    i2c_rbyte(1'b0, d0);
    i2c_rbyte(1'b1, d1);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL read_release_after_nack got=%b exp=0", sda_oe); end
    i2c_stop();
    model_set_ptr(8'h01); model_read(e0); model_read(e1);
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL read_acks got=%b exp=111", {a0, a1, a2}); end
    checks++; if (d0 !== e0) begin failures++; $display("FAIL read_byte0 got=%h exp=%h", d0, e0); end
    checks++; if (d1 !== e1) begin failures++; $display("FAIL read_byte1 got=%h exp=%h", d1, e1); end
    checks++; if (got_wr.size() != 0) begin failures++; $display("FAIL read_wr_count got=%0d exp=0", got_wr.size()); end
  endtask

  task automatic test_partial();
    bit a0, a1, a2, a3, a4;
    logic r;
    clear_logs();
    i2c_start();
    i2c_wbyte(8'h94, a0); i2c_wbyte(8'h03, a1);
    for (int i = 0; i < 5; i++) i2c_bit(1'($urandom_range(0, 1)), r);
    i2c_stop();
    model_set_ptr(8'h03);
    checks++; if (got_wr.size() != 0) begin failures++; $display("FAIL partial_wr_count got=%0d exp=0", got_wr.size()); end
    i2c_start();
    i2c_wbyte(8'h94, a2); i2c_wbyte(8'h07, a3); i2c_wbyte(8'h3c, a4);
    i2c_stop();
    model_set_ptr(8'h07); model_write(8'h3c);
    checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin failures++; $display("FAIL partial_acks got=%b exp=11111", {a0, a1, a2, a3, a4}); end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL partial_after_wr_count got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL partial_after_wr%0d got a=%h d=%h exp a=%h d=%h", i, got_wr[i].a, got_wr[i].d, exp_wr[i].a, exp_wr[i].d); end
    end
  endtask

  task automatic test_reset_mid();
    logic r;
    logic [7:0] addr_w;
    bit a0, a1, a2;
    int k;
    clear_logs();
    addr_w = 8'h94;
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(addr_w[i], r);
    k = 0;
    while (sda_oe !== 1'b1 && k < 20) begin wclk(1); k++; end
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rstmid_ack_start got=%b exp=1", sda_oe); end
    rst_n = 1'b0;
    wclk(1);
    rst_n = 1'b1;
    mptr = 0;
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rstmid_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (csr_a !== '0)    begin failures++; $display("FAIL rstmid_csr_a got=%h exp=0", csr_a); end
    tb_sda = 1'b1; wclk(3);
    scl = 1'b1;    wclk(4);
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL rstmid_no_ack got=%b exp=1", sda_bus); end
    wclk(4);
    scl = 1'b0;    wclk(4);
    i2c_stop();
    i2c_start();
    i2c_wbyte(8'h94, a0); i2c_wbyte(8'h00, a1); i2c_wbyte(8'h55, a2);
    i2c_stop();
    model_set_ptr(8'h00); model_write(8'h55);
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL rstmid_acks got=%b exp=111", {a0, a1, a2}); end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL rstmid_wr_count got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL rstmid_wr%0d got a=%h d=%h exp a=%h d=%h", i, got_wr[i].a, got_wr[i].d, exp_wr[i].a, exp_wr[i].d); end
    end
  endtask

  task automatic test_random();
    bit ack, all_ack;
    logic [7:0] p, d, e;
    int n;
    for (int it = 0; it < 12; it++) begin
      clear_logs();
      all_ack = 1'b1;
      case ($urandom_range(0, 4))
        0:       p = {3'b000, WDT_BASE};
        1:       p = {3'b000, GPIO_BASE};
        2:       p = {3'b000, CNT_BASE};
        3:       p = {3'b000, LED_BASE} + 8'h07;
        default: p = 8'($urandom);
      endcase
      n = $urandom_range(1, 3);
      i2c_start();
      i2c_wbyte(8'h94, ack); all_ack &= ack;
      i2c_wbyte(p, ack);     all_ack &= ack;
      model_set_ptr(p);
      if ($urandom_range(0, 1) == 0) begin
        for (int j = 0; j < n; j++) begin
          d = 8'($urandom);
          i2c_wbyte(d, ack); all_ack &= ack;
          model_write(d);
        end
      end else begin
        i2c_start();
        i2c_wbyte(8'h95, ack); all_ack &= ack;
        for (int j = 0; j < n; j++) begin
          i2c_rbyte(j == n - 1, d);
          model_read(e);
          checks++; if (d !== e) begin failures++; $display("FAIL rand%0d_rd%0d got=%h exp=%h", it, j, d, e); end
        end
      end
      i2c_stop();
      checks++; if (all_ack !== 1'b1) begin failures++; $display("FAIL rand%0d_acks got=%b exp=1", it, all_ack); end
      checks++;
      if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL rand%0d_wr_count got=%0d exp=%0d", it, got_wr.size(), exp_wr.size()); end
      else foreach (exp_wr[i]) begin
        checks++;
        if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL rand%0d_wr%0d got a=%h d=%h exp a=%h d=%h", it, i, got_wr[i].a, got_wr[i].d, exp_wr[i].a, exp_wr[i].d); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wrong_addr();
    test_wrap();
    test_read();
    test_partial();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
